enigma_rotor_stage: RTL
=======================

Name: enigma_rotor_stage

Overview:
Parametrised, field-programmable Enigma rotor stage replacing the fixed per-rotor forward and inverse modules. One instance provides both the forward path (keyboard→reflector) and the inverse path (reflector→lamp) through a loadable wiring table. It holds the rotor position, ring setting and notch, steps on request, and emits a carry pulse to the next stage. It sits in the rotor chain between the plugboard and the reflector; the chain controller drives its step input.

Parameters:
N_SYM, 26, alphabet size; symbols are encoded 1..N_SYM, and 0 is invalid.
W, 5, symbol/index width; must satisfy 2^W > N_SYM.
NOTCH_RST, 21, notch position (zero-based) loaded at reset; 21 = 'V'.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
clear_req  in  1  pulse: wipe the wiring table (re-enter CLEAR)
cfg_we  in  1  write wiring entry: symbol cfg_idx maps to cfg_val
cfg_idx  in  W  forward input symbol, 1..N_SYM
cfg_val  in  W  forward output symbol, 1..N_SYM
cfg_pos_we  in  1  load position, ring and notch
cfg_pos  in  W  position, 0..N_SYM-1
cfg_ring  in  W  ring setting, 0..N_SYM-1
cfg_notch  in  W  notch position, 0..N_SYM-1
cfg_err  out  1  1-cycle pulse: a rejected configuration write
step_in  in  1  advance position by one
carry_out  out  1  1-cycle pulse: stepped off the notch position
in_valid  in  1  input symbol present
in_ready  out  1  stage can accept a symbol
in_dir  in  1  0 = forward, 1 = inverse
in_sym  in  W  input symbol
out_valid  out  1  result present (1-cycle pulse per input)
out_sym  out  W  translated symbol, 1..N_SYM; 0 on error
out_err  out  1  input out of range, or table entry unprogrammed
pos  out  W  current position, for the display

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pos = 0, ring = 0, notch = NOTCH_RST.
  - out_valid = 0, out_sym = 0, out_err = 0.
  - carry_out = 0, cfg_err = 0.
  - Pipeline valid bits are cleared, and the FSM enters CLEAR.
- Reset mid-operation drops in-flight symbols; no out_valid is produced for them.
- FSM, CLEAR state:
  - A counter runs 0..N_SYM-1, clearing one forward-valid and one inverse-valid bit per cycle.
  - After N_SYM cycles the FSM moves to RUN.
  - in_ready = 0; cfg_we and cfg_pos_we are ignored, and no cfg_err is raised.
  - step_in is still honoured.
- FSM, RUN state:
  - in_ready = 1.
  - clear_req moves the FSM to CLEAR on the next cycle. Any symbol already accepted completes normally.
- Table:
  - Forward table fwd[0..N-1] and inverse table inv[0..N-1] each store a zero-based value plus a valid bit.
  - cfg_we with both symbols in range writes fwd[idx-1] = val-1 and inv[val-1] = idx-1, setting both valid bits.
  - If either symbol is out of range (0 or >N_SYM), the write is ignored and cfg_err pulses on the next cycle.
  - Overwriting an entry does not clear the stale inverse entry; software reprograms the full table after clear_req.
- Translation (off = (pos - ring) mod N):
  - idx = (in_sym - 1 + off) mod N.
  - t = (dir ? inv : fwd)[idx].
  - out_sym = ((t - off) mod N) + 1.
  - All mod-N arithmetic uses W+1-bit intermediates with a conditional add or subtract of N; no divider.
- Latency and throughput:
  - A symbol accepted at cycle k (in_valid & in_ready) produces out_valid at k+2.
  - Stage 1 registers idx, dir, off and the range flag; stage 2 performs the table read and output arithmetic.
  - Throughput is 1 symbol per cycle.
- Errors:
  - Input 0 or >N_SYM, or an invalid table entry, gives out_err = 1 and out_sym = 0, with out_valid still asserted.
- Stepping:
  - step_in: pos <= (pos == N-1) ? 0 : pos + 1.
  - carry_out pulses on the next cycle if pos == notch when the step is taken.
- Priority:
  - cfg_pos_we beats step_in: the position is loaded, no step occurs and no carry is raised.
- Simultaneous events:
  - A symbol accepted in the same cycle as step_in or cfg_pos_we uses the pre-update pos and ring.
  - cfg_we in the same cycle as an accept: the table write is visible to symbols accepted from the next cycle.
  - A stage-2 read in the same cycle as a write to the same entry returns the old value.

Test Plan:
1. Reset, then wait -> in_ready stays 0 for exactly 26 cycles, then 1; pos = 0. Forward input 1 -> out_valid after 2 cycles, out_err = 1, out_sym = 0.
2. Program rotor III (BDFHJLCPRTXVZNYEIWGAKMUSQO: 1→2, 2→4, ...). At pos = 0, ring = 0: forward 1 → 2, forward 2 → 4; inverse 4 → 2.
3. cfg_pos_we with pos = 1, ring = 0 -> forward 1 → 3, inverse 3 → 1. Setting ring = 1 at the same pos -> results match pos = 0.
4. Back-to-back: stream 26 forward symbols 1..26 on consecutive cycles -> 26 consecutive out_valid cycles, starting 2 cycles after the first accept, with no gaps. Feeding each result through inverse returns the original symbol.
5. notch = 21, pos = 20: step -> pos = 21, no carry. Step -> pos = 22, carry_out = 1 for 1 cycle. Step at pos = 25 -> pos = 0. Assert step_in and cfg_pos_we (pos = 5) together -> pos = 5, no carry.
6. cfg_we with cfg_idx = 0 or cfg_val = 27 -> cfg_err pulse and table unchanged. clear_req in RUN -> in_ready low for 26 cycles, then every lookup returns out_err = 1. Assert rst while 2 symbols are in flight -> no out_valid follows.

Source files
------------

// File: rtl/enigma_rotor_stage.sv
// Programmable Enigma rotor: forward/inverse wiring lookup, stepping with notch carry.
// Two-cycle lookup pipeline at one symbol per cycle; in_ready is low only while the table is being wiped.
module enigma_rotor_stage #(
    parameter int N_SYM     = 26,
    parameter int W         = 5,
    parameter int NOTCH_RST = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_req,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_idx,
    input  logic [W-1:0] cfg_val,
    input  logic         cfg_pos_we,
    input  logic [W-1:0] cfg_pos,
    input  logic [W-1:0] cfg_ring,
    input  logic [W-1:0] cfg_notch,
    output logic         cfg_err,
    input  logic         step_in,
    output logic         carry_out,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [W-1:0] in_sym,
    output logic         out_valid,
    output logic [W-1:0] out_sym,
    output logic         out_err,
    output logic [W-1:0] pos
);
    localparam logic [W:0]   N_W1 = (W+1)'(N_SYM);
    localparam logic [W-1:0] N_M1 = W'(N_SYM - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    function automatic logic sym_ok(input logic [W-1:0] s);
        return (s != '0) && ({1'b0, s} <= N_W1);
    endfunction

    function automatic logic zb_ok(input logic [W-1:0] s);
        return {1'b0, s} < N_W1;
    endfunction

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_W1) s = s - N_W1;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + N_W1;
        return s[W-1:0];
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [W-1:0]   pos_q, ring_q, notch_q;
    logic           carry_q, cfg_err_q;
    logic [W-1:0]   fwd_q [N_SYM];
    logic [W-1:0]   inv_q [N_SYM];
    logic           fwd_vld_q [N_SYM];
    logic           inv_vld_q [N_SYM];

    logic           s1_vld_q, s1_dir_q, s1_err_q;
    logic [W-1:0]   s1_idx_q, s1_off_q;
    logic           out_vld_q, out_err_q;
    logic [W-1:0]   out_sym_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        in_ready  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == N_M1) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ONE;
                end
            end
            default: begin
                in_ready = 1'b1;
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    logic run, wr_ok, pos_ok;
    assign run    = (state_q == ST_RUN);
    assign wr_ok  = sym_ok(cfg_idx) && sym_ok(cfg_val);
    assign pos_ok = zb_ok(cfg_pos) && zb_ok(cfg_ring) && zb_ok(cfg_notch);

    // Wiring data is never reset; only the valid bits matter and CLEAR wipes them.
    always_ff @(posedge clk) begin
        if (!run) begin
            fwd_vld_q[clr_cnt_q] <= 1'b0;
            inv_vld_q[clr_cnt_q] <= 1'b0;
        end else if (!rst && cfg_we && wr_ok) begin
            fwd_q[cfg_idx - ONE]     <= cfg_val - ONE;
            inv_q[cfg_val - ONE]     <= cfg_idx - ONE;
            fwd_vld_q[cfg_idx - ONE] <= 1'b1;
            inv_vld_q[cfg_val - ONE] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q     <= '0;
            ring_q    <= '0;
            notch_q   <= W'(NOTCH_RST);
            carry_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            carry_q   <= 1'b0;
            cfg_err_q <= run && ((cfg_we && !wr_ok) || (cfg_pos_we && !pos_ok));
            if (run && cfg_pos_we) begin
                if (pos_ok) begin
                    pos_q   <= cfg_pos;
                    ring_q  <= cfg_ring;
                    notch_q <= cfg_notch;
                end
            end else if (step_in) begin
                pos_q   <= (pos_q == N_M1) ? '0 : pos_q + ONE;
                carry_q <= (pos_q == notch_q);
            end
        end
    end

    logic         acc, in_ok;
    logic [W-1:0] off, idx;
    assign acc   = in_valid && in_ready;
    assign in_ok = sym_ok(in_sym);
    assign off   = sub_mod(pos_q, ring_q);
    assign idx   = in_ok ? add_mod(in_sym - ONE, off) : '0;

    logic [W-1:0] rd_val;
    logic         rd_vld, s2_err;
    assign rd_val = s1_dir_q ? inv_q[s1_idx_q] : fwd_q[s1_idx_q];
    assign rd_vld = s1_dir_q ? inv_vld_q[s1_idx_q] : fwd_vld_q[s1_idx_q];
    assign s2_err = s1_err_q || !rd_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_dir_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_off_q  <= '0;
            out_vld_q <= 1'b0;
            out_err_q <= 1'b0;
            out_sym_q <= '0;
        end else begin
            s1_vld_q  <= acc;
            s1_dir_q  <= in_dir;
            s1_err_q  <= !in_ok;
            s1_idx_q  <= idx;
            s1_off_q  <= off;
            out_vld_q <= s1_vld_q;
            out_err_q <= s1_vld_q && s2_err;
            out_sym_q <= (s1_vld_q && !s2_err) ? sub_mod(rd_val, s1_off_q) + ONE : '0;
        end
    end

    assign cfg_err   = cfg_err_q;
    assign carry_out = carry_q;
    assign out_valid = out_vld_q;
    assign out_sym   = out_sym_q;
    assign out_err   = out_err_q;
    assign pos       = pos_q;
endmodule
